// File: rtl/nes_multi_controller.sv
// Multi-pad NES/SNES serial controller reader: one shared latch/clock pair,
// per-pad data lines, optional auto-poll and per-button press/release flags.
module nes_multi_controller #(
  parameter int unsigned NUM_PADS         = 2,
  parameter int unsigned BITS_PER_PAD     = 8,
  parameter int unsigned CYCLES_PER_BIT   = 10,
  parameter int unsigned AUTO_POLL_CYCLES = 0
) (
  input  logic                                 clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_read_buttons,
  output logic                                 o_busy,
  output logic                                 o_valid,
  output logic [NUM_PADS*BITS_PER_PAD-1:0]     o_buttons,
  output logic [NUM_PADS*BITS_PER_PAD-1:0]     o_pressed,
  output logic [NUM_PADS*BITS_PER_PAD-1:0]     o_released,
  input  logic [NUM_PADS-1:0]                  i_controller_data,
  output logic                                 o_controller_latch,
  output logic                                 o_controller_clock
);

  localparam int unsigned N     = NUM_PADS;
  localparam int unsigned B     = BITS_PER_PAD;
  localparam int unsigned C     = CYCLES_PER_BIT;
  localparam int unsigned H     = C / 2;
  localparam int unsigned W     = N * B;
  localparam int unsigned W_PH  = $clog2(C);
  localparam int unsigned W_BIT = $clog2(B);

  localparam logic [W_PH-1:0]  PH_LAST   = W_PH'(C - 1);
  localparam logic [W_PH-1:0]  PH_SAMPLE = W_PH'(H - 1);
  localparam logic [W_PH-1:0]  PH_HALF   = W_PH'(H);
  localparam logic [W_BIT-1:0] BIT_LAST  = W_BIT'(B - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q,    state_d;
  logic [W_PH-1:0]  phase_q,    phase_d;
  logic [W_BIT-1:0] bit_q,      bit_d;
  logic [W-1:0]     sample_q,   sample_d;
  logic [W-1:0]     prev_q,     prev_d;
  logic [W-1:0]     buttons_q,  buttons_d;
  logic [W-1:0]     pressed_q,  pressed_d;
  logic [W-1:0]     released_q, released_d;
  logic             latch_q,    latch_d;
  logic             sclk_q,     sclk_d;
  logic             busy_q,     busy_d;
  logic             valid_q,    valid_d;

  logic poll_tick;
  logic read_req;

  // Free-running auto-poll tick generator; absent entirely when disabled.
  generate
    if (AUTO_POLL_CYCLES > 0) begin : g_poll
      localparam int unsigned W_AP = (AUTO_POLL_CYCLES > 1) ? $clog2(AUTO_POLL_CYCLES) : 1;
      localparam logic [W_AP-1:0] AP_LAST = W_AP'(AUTO_POLL_CYCLES - 1);

      logic [W_AP-1:0] poll_cnt_q, poll_cnt_d;

      always_comb begin
        poll_cnt_d = poll_cnt_q + W_AP'(1);
        if (poll_cnt_q == AP_LAST) begin
          poll_cnt_d = '0;
        end
      end

      always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          poll_cnt_q <= '0;
        end else begin
          poll_cnt_q <= poll_cnt_d;
        end
      end

      assign poll_tick = (poll_cnt_q == AP_LAST);
    end else begin : g_no_poll
      assign poll_tick = 1'b0;
    end
  endgenerate

  assign read_req = i_read_buttons | poll_tick;

  // Next-state, shift capture and registered-output decode.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    sample_d   = sample_q;
    prev_d     = prev_q;
    buttons_d  = buttons_q;
    pressed_d  = pressed_q;
    released_d = released_q;

    case (state_q)
      S_IDLE: begin
        if (read_req) begin
          state_d = S_LATCH;
          phase_d = '0;
        end
      end
      S_LATCH: begin
        if (phase_q == PH_LAST) begin
          state_d = S_SHIFT;
          phase_d = '0;
          bit_d   = '0;
        end else begin
          phase_d = phase_q + W_PH'(1);
        end
      end
      S_SHIFT: begin
        // Data lines are active low; each pad's bits enter at the MSB so slot 0 ends in bit 0.
        if (phase_q == PH_SAMPLE) begin
          for (int unsigned p = 0; p < N; p++) begin
            sample_d[p*B +: B] = {~i_controller_data[p], sample_q[p*B+1 +: B-1]};
          end
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + W_BIT'(1);
          end
        end else begin
          phase_d = phase_q + W_PH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_DONE) begin
      buttons_d  = sample_q;
      pressed_d  = sample_q & ~prev_q;
      released_d = prev_q & ~sample_q;
      prev_d     = sample_q;
    end

    latch_d = (state_d == S_LATCH);
    sclk_d  = (state_d == S_SHIFT) && (phase_d >= PH_HALF) && (bit_d != BIT_LAST);
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      bit_q      <= '0;
      sample_q   <= '0;
      prev_q     <= '0;
      buttons_q  <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      latch_q    <= 1'b0;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      sample_q   <= sample_d;
      prev_q     <= prev_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      latch_q    <= latch_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign o_busy             = busy_q;
  assign o_valid            = valid_q;
  assign o_buttons          = buttons_q;
  assign o_pressed          = pressed_q;
  assign o_released         = released_q;
  assign o_controller_latch = latch_q;
  assign o_controller_clock = sclk_q;

endmodule
